peak_sorter: RTL

- Downstream consumer of the per-bin magnitude stream produced by the frequency buffer stage.
- Tracks the NUM_PEAKS largest magnitudes in a frame, with their bin indices, in a sorted insertion register.
- At end of frame it drains them in descending order over a valid/ready source interface to the peak-reporting logic.

---
 rtl/peak_sorter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/peak_sorter.sv
// Keeps the NUM_PEAKS largest magnitudes of a frame in a sorted insertion register
// and drains them largest-first over a valid/ready source port at end of frame.
module peak_sorter #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 10,
    parameter int NUM_PEAKS  = 4
) (
    input  logic                  sink_clk,
    input  logic                  reset,
    input  logic                  sink_valid,
    output logic                  sink_ready,
    input  logic                  sink_sop,
    input  logic                  sink_eop,
    input  logic [DATA_WIDTH-1:0] sink_mag,
    input  logic [IDX_WIDTH-1:0]  sink_idx,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic                  source_sop,
    output logic                  source_eop,
    output logic [DATA_WIDTH-1:0] source_mag,
    output logic [IDX_WIDTH-1:0]  source_idx,
    output logic [15:0]           drop_cnt
);
    localparam int CW = $clog2(NUM_PEAKS + 1);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t                state;
    logic [1:0]            rst_sync;
    logic                  rst_n;
    logic                  vld_q [NUM_PEAKS];
    logic [DATA_WIDTH-1:0] mag_q [NUM_PEAKS];
    logic [IDX_WIDTH-1:0]  idx_q [NUM_PEAKS];
    logic                  nv    [NUM_PEAKS];
    logic [DATA_WIDTH-1:0] nm    [NUM_PEAKS];
    logic [IDX_WIDTH-1:0]  ni    [NUM_PEAKS];
    logic [CW-1:0]         ptr, k, cnt, rd_p;
    logic [DATA_WIDTH-1:0] rd_mag;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic                  accept;

    // Assert asynchronously, release two edges later.
    always_ff @(posedge sink_clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n  = rst_sync[1];
    assign accept = sink_valid & sink_ready;

    // Insertion: strict less-than keeps an equal, earlier entry ahead.
    always_comb begin
        logic                  found;
        logic                  bv, pv;
        logic [DATA_WIDTH-1:0] pm;
        logic [IDX_WIDTH-1:0]  pi;
        found = 1'b0;
        pv    = 1'b0;
        pm    = '0;
        pi    = '0;
        cnt   = '0;
        for (int i = 0; i < NUM_PEAKS; i++) begin
            bv = vld_q[i] & ~sink_sop;
            if (found) begin
                nv[i] = pv;
                nm[i] = pm;
                ni[i] = pi;
            end else if (!bv || mag_q[i] < sink_mag) begin
                nv[i] = 1'b1;
                nm[i] = sink_mag;
                ni[i] = sink_idx;
                found = 1'b1;
            end else begin
                nv[i] = bv;
                nm[i] = mag_q[i];
                ni[i] = idx_q[i];
            end
            pv  = bv;
            pm  = mag_q[i];
            pi  = idx_q[i];
            cnt = cnt + CW'(nv[i]);
        end
    end

    always_comb begin
        rd_p   = source_valid ? ptr + CW'(1) : ptr;
        rd_mag = '0;
        rd_idx = '0;
        for (int i = 0; i < NUM_PEAKS; i++) begin
            if (CW'(i) == rd_p) begin
                rd_mag = mag_q[i];
                rd_idx = idx_q[i];
            end
        end
    end

    always_ff @(posedge sink_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= COLLECT;
            sink_ready   <= 1'b1;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_mag   <= '0;
            source_idx   <= '0;
            drop_cnt     <= '0;
            ptr          <= '0;
            k            <= '0;
            for (int i = 0; i < NUM_PEAKS; i++) begin
                vld_q[i] <= 1'b0;
                mag_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else begin
            if (sink_valid && !sink_ready && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        for (int i = 0; i < NUM_PEAKS; i++) begin
                            vld_q[i] <= nv[i];
                            mag_q[i] <= nm[i];
                            idx_q[i] <= ni[i];
                        end
                        if (sink_eop) begin
                            state      <= DRAIN;
                            sink_ready <= 1'b0;
                            k          <= cnt;
                            ptr        <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (!source_valid || source_ready) begin
                        if (source_valid && source_eop) begin
                            for (int i = 0; i < NUM_PEAKS; i++)
                                vld_q[i] <= 1'b0;
                            state        <= COLLECT;
                            sink_ready   <= 1'b1;
                            source_valid <= 1'b0;
                            source_sop   <= 1'b0;
                            source_eop   <= 1'b0;
                        end else begin
                            ptr          <= rd_p;
                            source_valid <= 1'b1;
                            source_mag   <= rd_mag;
                            source_idx   <= rd_idx;
                            source_sop   <= (rd_p == '0);
                            source_eop   <= (rd_p == k - CW'(1));
                        end
                    end
                end
            endcase
        end
    end
endmodule
